// File: rtl/clock_pulse_gen.sv
// Programmable square-wave / pulse-train generator running off the system clock.
// Configuration is captured when a sequence starts, and a zero length is
// treated as one. A down-counter times each HIGH and LOW phase. In burst mode
// an up-counter tracks how many periods have completed. Every output comes
// straight from a flop, so edge strobes and done line up with pulse_out.

module clock_pulse_gen #(
  parameter int CNT_W   = 16,
  parameter int BURST_W = 8
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               start,
  input  logic               stop,
  input  logic               mode,
  input  logic [CNT_W-1:0]   high_cycles,
  input  logic [CNT_W-1:0]   low_cycles,
  input  logic [BURST_W-1:0] burst_len,
  output logic               pulse_out,
  output logic               edge_rise,
  output logic               edge_fall,
  output logic               busy,
  output logic               done
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HIGH = 2'd1,
    S_LOW  = 2'd2
  } state_e;

  localparam logic [CNT_W-1:0]   CNT_ZERO   = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]   CNT_ONE    = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [BURST_W-1:0] BURST_ZERO = {BURST_W{1'b0}};
  localparam logic [BURST_W-1:0] BURST_ONE  = {{(BURST_W-1){1'b0}}, 1'b1};

  // A phase length of zero would never terminate; run it as one cycle instead.
  function automatic logic [CNT_W-1:0] map_cnt(input logic [CNT_W-1:0] v);
    map_cnt = (v == CNT_ZERO) ? CNT_ONE : v;
  endfunction

  // A burst of zero periods is meaningless; run it as a single period.
  function automatic logic [BURST_W-1:0] map_burst(input logic [BURST_W-1:0] v);
    map_burst = (v == BURST_ZERO) ? BURST_ONE : v;
  endfunction

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;

  logic               mode_q, mode_d;
  logic [CNT_W-1:0]   high_q, high_d;
  logic [CNT_W-1:0]   low_q, low_d;
  logic [BURST_W-1:0] burst_q, burst_d;

  logic               pulse_q, pulse_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               load_cfg_s;
  logic [CNT_W-1:0]   high_in_s;
  logic               last_period_s;

  assign high_in_s     = map_cnt(high_cycles);
  // The counter holds completed periods, so the final period is reached when it equals B-1.
  assign last_period_s = mode_q && (burst_cnt_q == (burst_q - BURST_ONE));

  // Next-state, counter and registered-output logic for the IDLE/HIGH/LOW sequencer.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    burst_cnt_d = burst_cnt_q;
    pulse_d     = 1'b0;
    rise_d      = 1'b0;
    fall_d      = 1'b0;
    busy_d      = 1'b0;
    done_d      = 1'b0;
    load_cfg_s  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start && !stop) begin
          load_cfg_s  = 1'b1;
          state_d     = S_HIGH;
          cnt_d       = high_in_s - CNT_ONE;
          burst_cnt_d = BURST_ZERO;
          pulse_d     = 1'b1;
          rise_d      = 1'b1;
          busy_d      = 1'b1;
        end else begin
          state_d     = S_IDLE;
          cnt_d       = CNT_ZERO;
          burst_cnt_d = BURST_ZERO;
        end
      end

      S_HIGH: begin
        if (stop) begin
          // pulse_out is high throughout HIGH, so an abort here is always a falling edge.
          state_d     = S_IDLE;
          cnt_d       = CNT_ZERO;
          burst_cnt_d = BURST_ZERO;
          fall_d      = 1'b1;
        end else if (cnt_q == CNT_ZERO) begin
          state_d = S_LOW;
          cnt_d   = low_q - CNT_ONE;
          fall_d  = 1'b1;
          busy_d  = 1'b1;
        end else begin
          cnt_d   = cnt_q - CNT_ONE;
          pulse_d = 1'b1;
          busy_d  = 1'b1;
        end
      end

      S_LOW: begin
        if (stop) begin
          state_d     = S_IDLE;
          cnt_d       = CNT_ZERO;
          burst_cnt_d = BURST_ZERO;
        end else if (cnt_q == CNT_ZERO) begin
          if (last_period_s) begin
            state_d     = S_IDLE;
            cnt_d       = CNT_ZERO;
            burst_cnt_d = BURST_ZERO;
            done_d      = 1'b1;
          end else begin
            state_d = S_HIGH;
            cnt_d   = high_q - CNT_ONE;
            pulse_d = 1'b1;
            rise_d  = 1'b1;
            busy_d  = 1'b1;
            if (mode_q) begin
              burst_cnt_d = burst_cnt_q + BURST_ONE;
            end else begin
              burst_cnt_d = burst_cnt_q;
            end
          end
        end else begin
          cnt_d  = cnt_q - CNT_ONE;
          busy_d = 1'b1;
        end
      end

      default: begin
        state_d     = S_IDLE;
        cnt_d       = CNT_ZERO;
        burst_cnt_d = BURST_ZERO;
      end
    endcase
  end

  // Configuration shadow registers: captured only when a sequence is accepted.
  always_comb begin
    mode_d  = mode_q;
    high_d  = high_q;
    low_d   = low_q;
    burst_d = burst_q;
    if (load_cfg_s) begin
      mode_d  = mode;
      high_d  = high_in_s;
      low_d   = map_cnt(low_cycles);
      burst_d = map_burst(burst_len);
    end else begin
      mode_d  = mode_q;
      high_d  = high_q;
      low_d   = low_q;
      burst_d = burst_q;
    end
  end

  // Sequencer state and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      cnt_q       <= CNT_ZERO;
      burst_cnt_q <= BURST_ZERO;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      burst_cnt_q <= burst_cnt_d;
    end
  end

  // Latched configuration.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mode_q  <= 1'b0;
      high_q  <= CNT_ZERO;
      low_q   <= CNT_ZERO;
      burst_q <= BURST_ZERO;
    end else begin
      mode_q  <= mode_d;
      high_q  <= high_d;
      low_q   <= low_d;
      burst_q <= burst_d;
    end
  end

  // Registered outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pulse_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      pulse_q <= pulse_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign pulse_out = pulse_q;
  assign edge_rise = rise_q;
  assign edge_fall = fall_q;
  assign busy      = busy_q;
  assign done      = done_q;

  clock_pulse_gen_chk u_chk (
    .clock     (clock),
    .reset     (reset),
    .edge_rise (rise_q),
    .edge_fall (fall_q),
    .busy      (busy_q),
    .done      (done_q)
  );

endmodule

// Output invariants of the generator: edges are mutually exclusive and done
// only appears once the sequencer is no longer busy.
module clock_pulse_gen_chk (
  input logic clock,
  input logic reset,
  input logic edge_rise,
  input logic edge_fall,
  input logic busy,
  input logic done
);

  a_edges_exclusive: assert property (@(posedge clock) disable iff (reset)
    !(edge_rise && edge_fall));

  a_done_not_busy: assert property (@(posedge clock) disable iff (reset)
    !(done && busy));

endmodule

// File: tb/tb_clock_pulse_gen.sv
// Self-checking bench for clock_pulse_gen: hand-derived vector table, directed
// corner sequences, and randomized traffic against a period-arithmetic model.

module tb_clock_pulse_gen;

  logic        clock;
  logic        reset;
  logic        start;
  logic        stop;
  logic        mode;
  logic [15:0] high_cycles;
  logic [15:0] low_cycles;
  logic [7:0]  burst_len;
  logic        pulse_out;
  logic        edge_rise;
  logic        edge_fall;
  logic        busy;
  logic        done;

  int total = 0;
  int bad   = 0;

  clock_pulse_gen #(.CNT_W(16), .BURST_W(8)) dut (
    .clock       (clock),
    .reset       (reset),
    .start       (start),
    .stop        (stop),
    .mode        (mode),
    .high_cycles (high_cycles),
    .low_cycles  (low_cycles),
    .burst_len   (burst_len),
    .pulse_out   (pulse_out),
    .edge_rise   (edge_rise),
    .edge_fall   (edge_fall),
    .busy        (busy),
    .done        (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  // Position in the sequence is the count n of cycles since the start edge;
  // pulse is high while ((n-1) mod (H+L)) < H, edges are pulse transitions.
  bit m_active, m_mode, m_pulse, m_rise, m_fall, m_done;
  int m_h, m_l, m_b, m_n;

  function void model_reset();
    m_active = 1'b0; m_mode = 1'b0; m_pulse = 1'b0;
    m_rise = 1'b0; m_fall = 1'b0; m_done = 1'b0;
    m_h = 0; m_l = 0; m_b = 0; m_n = 0;
  endfunction

  function void model_edge();
    bit np;
    if (reset) begin
      model_reset();
      return;
    end
    m_done = 1'b0;
    if (m_active) begin
      if (stop) begin
        m_active = 1'b0;
      end else begin
        m_n = m_n + 1;
        if (m_mode && (m_n == 1 + m_b * (m_h + m_l))) begin
          m_active = 1'b0;
          m_done   = 1'b1;
        end
      end
    end else if (start && !stop) begin
      m_mode   = mode;
      m_h      = (high_cycles == 16'd0) ? 1 : int'(high_cycles);
      m_l      = (low_cycles == 16'd0) ? 1 : int'(low_cycles);
      m_b      = (burst_len == 8'd0) ? 1 : int'(burst_len);
      m_active = 1'b1;
      m_n      = 1;
    end
    np      = m_active ? (((m_n - 1) % (m_h + m_l)) < m_h) : 1'b0;
    m_rise  = np & ~m_pulse;
    m_fall  = ~np & m_pulse;
    m_pulse = np;
  endfunction

  function logic [4:0] obs();
    return {pulse_out, edge_rise, edge_fall, busy, done};
  endfunction

  task automatic check_val(input string name, input logic [4:0] exp);
    total++;
    if (obs() !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got {pulse,rise,fall,busy,done}=%b want=%b", name, $time, obs(), exp);
    end
  endtask

  task automatic check_model(input string name);
    check_val(name, {m_pulse, m_rise, m_fall, m_active, m_done});
  endtask

  task automatic check_int(input string name, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, exp);
    end
  endtask

  // Drive inputs at the falling edge, let the rising edge happen, update model, settle.
  task automatic tick_full(input logic r, input logic s, input logic p, input logic m,
                           input logic [15:0] h, input logic [15:0] l, input logic [7:0] b);
    @(negedge clock);
    reset = r; start = s; stop = p; mode = m;
    high_cycles = h; low_cycles = l; burst_len = b;
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic tick(input logic s, input logic p, input logic m,
                      input logic [15:0] h, input logic [15:0] l, input logic [7:0] b);
    tick_full(1'b0, s, p, m, h, l, b);
  endtask

  task automatic idle();
    tick(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0);
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        st;
    logic        sp;
    logic        md;
    logic [15:0] h;
    logic [15:0] l;
    logic [7:0]  b;
    logic [4:0]  exp;   // {pulse, rise, fall, busy, done} after the edge
  } vec_t;

  localparam int NV = 27;
  vec_t vecs[NV];

  initial begin
    int rises, falls, busy_cnt, high_run, done_seen;
    logic [9:0] pat10;
    logic [7:0] pat8;
    bit seen_low;

    // burst B=2 H=1 L=1
    vecs[0]  = '{1'b1, 1'b0, 1'b1, 16'd1, 16'd1, 8'd2, 5'b11010};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00110};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b11010};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00110};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00001};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00000};
    // zero mapping H=0 L=0 B=0 burst
    vecs[6]  = '{1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 8'd0, 5'b11010};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00110};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00001};
    // start in the done cycle is accepted
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 16'd0, 16'd0, 8'd0, 5'b11010};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00110};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00001};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00000};
    // start+stop in IDLE, stop in IDLE
    vecs[13] = '{1'b1, 1'b1, 1'b0, 16'd2, 16'd2, 8'd0, 5'b00000};
    vecs[14] = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00000};
    // continuous H=4 L=4, start while busy ignored, stop in HIGH, restart
    vecs[15] = '{1'b1, 1'b0, 1'b0, 16'd4, 16'd4, 8'd0, 5'b11010};
    vecs[16] = '{1'b1, 1'b0, 1'b1, 16'd1, 16'd1, 8'd1, 5'b10010};
    vecs[17] = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00100};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00000};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00000};
    vecs[20] = '{1'b1, 1'b0, 1'b0, 16'd4, 16'd4, 8'd0, 5'b11010};
    vecs[21] = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00100};
    vecs[22] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00000};
    // stop in LOW gives no edge
    vecs[23] = '{1'b1, 1'b0, 1'b0, 16'd1, 16'd3, 8'd0, 5'b11010};
    vecs[24] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00110};
    vecs[25] = '{1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00000};
    vecs[26] = '{1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0, 5'b00000};

    reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
    high_cycles = 16'd0; low_cycles = 16'd0; burst_len = 8'd0;
    model_reset();

    // Reset state
    @(posedge clock);
    #1;
    check_val("reset_state", 5'b00000);
    tick(1'b0, 1'b0, 1'b0, 16'd0, 16'd0, 8'd0);
    check_val("after_release", 5'b00000);

    // Table-driven vectors
    for (int i = 0; i < NV; i++) begin
      tick(vecs[i].st, vecs[i].sp, vecs[i].md, vecs[i].h, vecs[i].l, vecs[i].b);
      check_val($sformatf("vec%0d", i), vecs[i].exp);
    end

    // Continuous H=3 L=2 over 20 periods; config noise while busy
    rises = 0; falls = 0; busy_cnt = 0; pat10 = 10'd0;
    tick(1'b1, 1'b0, 1'b0, 16'd3, 16'd2, 8'd0);
    for (int c = 1; c <= 100; c++) begin
      if (c > 1) begin
        tick(1'b0, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 9)),
             16'($urandom_range(0, 9)), 8'($urandom_range(0, 9)));
      end
      check_model("cont32");
      rises    += int'(edge_rise);
      falls    += int'(edge_fall);
      busy_cnt += int'(busy);
      if (c <= 10) pat10 = {pat10[8:0], pulse_out};
    end
    check_int("cont32_rises", rises, 20);
    check_int("cont32_falls", falls, 20);
    check_int("cont32_busy", busy_cnt, 100);
    check_int("cont32_pattern", int'(pat10), int'(10'b1110011100));
    tick(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 8'd0);
    check_model("cont32_stop");

    // Asynchronous reset in the LOW phase of a burst B=5 H=3 L=3
    tick(1'b1, 1'b0, 1'b1, 16'd3, 16'd3, 8'd5);
    check_model("rst_burst_c1");
    for (int c = 2; c <= 5; c++) begin
      idle();
      check_model("rst_burst_run");
    end
    check_val("rst_burst_in_low", 5'b00010);
    #3 reset = 1'b1;
    #1 check_val("async_reset_mid_low", 5'b00000);
    #2 reset = 1'b0;
    model_reset();
    @(posedge clock);
    model_edge();
    #1 check_model("after_async_reset");
    done_seen = 0;
    for (int c = 0; c < 30; c++) begin
      idle();
      check_model("post_reset_idle");
      done_seen += int'(done);
    end
    check_int("no_done_after_reset", done_seen, 0);
    pat8 = 8'd0;
    tick(1'b1, 1'b0, 1'b0, 16'd2, 16'd2, 8'd0);
    check_model("fresh_start");
    pat8 = {pat8[6:0], pulse_out};
    for (int c = 2; c <= 8; c++) begin
      idle();
      check_model("fresh_run");
      pat8 = {pat8[6:0], pulse_out};
    end
    check_int("fresh_pattern", int'(pat8), int'(8'b11001100));
    tick(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 8'd0);
    check_model("fresh_stop");

    // Randomized traffic with occasional reset
    for (int i = 0; i < 3000; i++) begin
      tick_full(1'($urandom_range(0, 199) == 0), 1'($urandom_range(0, 3) == 0),
                1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 1)),
                16'($urandom_range(0, 5)), 16'($urandom_range(0, 5)), 8'($urandom_range(0, 4)));
      check_model("random");
    end
    tick(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 8'd0);
    check_model("random_stop");

    // Maximum high phase, continuous; mid-run config change and start are ignored
    high_run = 0; seen_low = 1'b0;
    tick(1'b1, 1'b0, 1'b0, 16'hFFFF, 16'd1, 8'd0);
    for (int c = 1; c <= 65540; c++) begin
      if (c == 100) begin
        tick(1'b0, 1'b0, 1'b1, 16'd3, 16'd3, 8'd1);
      end else if (c == 200) begin
        tick(1'b1, 1'b0, 1'b1, 16'd2, 16'd2, 8'd1);
      end else if (c > 1) begin
        tick(1'b0, 1'b0, 1'b1, 16'd3, 16'd3, 8'd1);
      end
      check_model("max_high");
      if (!seen_low) begin
        if (pulse_out) high_run++;
        else seen_low = 1'b1;
      end
    end
    check_int("max_high_run", high_run, 65535);
    tick(1'b0, 1'b1, 1'b0, 16'd0, 16'd0, 8'd0);
    check_model("max_stop");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
